ldm_stm_sequencer: RTL and testbench
====================================

# ldm_stm_sequencer

Multi-cycle sequencer for ARM block transfers (LDM/STM). Sits directly upstream of the register file and beside the data memory. On a decoded block-transfer instruction it stalls the core and walks the 16-bit register list, one register per beat. Each beat it drives the register-file port address/write-enable and the memory address/write-enable, then optionally writes the updated base back to Rn.

## Interface
Parameters:
- ADDR_W, 32, memory address / base width.
- DATA_W, 32, register data width.

Ports:
- CLK  in  1  rising-edge clock.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  decoded LDM/STM valid; sampled only in IDLE.
- L  in  1  1 = load (LDM), 0 = store (STM).
- P  in  1  1 = pre-index, 0 = post-index.
- U  in  1  1 = up (increment), 0 = down (decrement).
- W  in  1  base writeback enable.
- RN  in  4  base register index.
- REGLIST  in  16  register list; bit i selects Ri.
- BASE  in  ADDR_W  current value of Rn.
- MEM_RDY  in  1  memory beat complete (LDM_WAIT_EN only).
- BUSY  out  1  stall PC/fetch.
- DONE  out  1  one-cycle completion pulse.
- ADDR  out  ADDR_W  memory word address for the current beat.
- MEM_WE  out  1  store beat (memory write).
- REG_A  out  4  register index: to A2 on stores, to A3 on loads/writeback.
- REG_WE  out  1  register-file write enable (drives WE3).
- PC_WE  out  1  load of R15 (drives the PC, not the register file).
- WB_SEL  out  1  1 = WD3 takes WB_DATA; 0 = WD3 takes memory read data.
- WB_DATA  out  DATA_W  updated base value.

## Operation
- Clocking and reset: one clock, CLK. Reset is asynchronous and active-low on RESET_N.
- On accept (IDLE and START), latch L/P/U/W/RN/BASE and the pending mask = REGLIST.
- Compute N = popcount(REGLIST), range 0..16; 4N is 7 bits, zero-extended.
- Start address, modulo 2^ADDR_W:
  - U=1: BASE + (P ? 4 : 0).
  - U=0: BASE − 4N + (P ? 0 : 4).
- Final base: U ? BASE+4N : BASE−4N.
- Beats always run in ascending register order at ascending addresses, +4 per beat.
- States:
  - IDLE: all outputs low.
  - XFER: REG_A = lowest set bit of the pending mask; ADDR = current address.
    - Store: MEM_WE = 1.
    - Load: REG_WE = beat_done & (REG_A≠15); PC_WE = beat_done & (REG_A==15); WB_SEL = 0.
    - On beat_done: clear that mask bit and add 4 to the address.
    - Leave XFER when the mask empties: go to WB if writeback applies, else FIN.
  - WB: REG_A = RN, REG_WE = 1, WB_SEL = 1, WB_DATA = final base; next state FIN.
  - FIN: DONE = 1; next state IDLE.
- BUSY = 1 in XFER and WB.
- Writeback applies when W & ¬(L & REGLIST[RN]); the loaded value wins over the updated base.
- Empty list (N=0): go IDLE → FIN directly, with no beats and no writeback.
- START outside IDLE is ignored.
- beat_done = MEM_RDY with LDM_WAIT_EN, otherwise 1.

## Timing
- State and address are registered. Outputs decode from state/registers (Moore), except REG_WE/PC_WE on loads, which also depend on MEM_RDY.
- START accepted at edge t: first beat is during cycle t+1.
- With zero wait states, DONE is high in cycle t+N+1, or t+N+2 with writeback.
- Stalled beat: ADDR, REG_A and MEM_WE are held stable until the edge where MEM_RDY=1.
- Reset (any time, including mid-sequence) forces IDLE, drops the pending transfer, and drives all outputs to 0: BUSY, DONE, MEM_WE, REG_WE, PC_WE, WB_SEL = 0; ADDR, REG_A, WB_DATA = 0.
- Address wrap-around at 2^ADDR_W is silent.

## Configuration
- LDM_WAIT_EN defined:
  - MEM_RDY port present.
  - Beats complete only on MEM_RDY=1.
- LDM_WAIT_EN undefined:
  - MEM_RDY port absent.
  - Every beat completes in one cycle.

## Structure
- Package ldm_stm_pkg holds:
  - state enum (IDLE, XFER, WB, FIN);
  - WORD_BYTES = 4;
  - REG_PC = 4'd15;
  - popcount16 function.
- Sub-module prio_enc16: 16-bit lowest-set-bit encoder; outputs index[3:0] and any.

## Test plan
- LDMIA R0!,{R1,R2,R4}, BASE=0x100 → beats (0x100,R1), (0x104,R2), (0x108,R4); WB R0=0x10C; DONE at t+5.
- STMDB R13!,{R4,R14}, BASE=0x200 → MEM_WE beats (0x1F8,R4), (0x1FC,R14); WB R13=0x1F8; no REG_WE during beats.
- LDMIB R2!,{R2,R15}, BASE=0x40 → R2 ← mem[0x44] with REG_WE; PC_WE at 0x48 with REG_WE=0; no WB state.
- REGLIST=0, W=1 → BUSY never asserts; DONE at t+1; no writes.
- LDM_WAIT_EN, MEM_RDY low 3 cycles on the second beat → ADDR/REG_A held for 4 cycles; exactly one REG_WE for that beat.
- RESET_N low during the second of 4 beats → all outputs 0 immediately; after release, IDLE accepts a new START normally.

Source files
------------

// File: rtl/ldm_stm_pkg.sv
// Shared types and helpers for the LDM/STM block-transfer sequencer.
package ldm_stm_pkg;

  // Sequencer phases: walk the register list, optionally write back the base, then pulse completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WB   = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam int          WORD_BYTES = 4;
  localparam logic [3:0]  REG_PC     = 4'd15;

  // Number of registers selected by a 16-bit list (0..16).
  function automatic logic [4:0] popcount16(input logic [15:0] bits);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + 5'(bits[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ldm_stm_sequencer_prio_enc16.sv
// Lowest-set-bit encoder: picks the next register of a pending transfer list.
module prio_enc16 (
  input  logic [15:0] bits,
  output logic [3:0]  index,
  output logic        any
);

  // Scan from the top down so the last hit (the lowest set bit) wins.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    index = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (bits[i]) index = 4'(i);
    end
    any = |bits;
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: stalls the core and issues one register per beat,
// then optionally writes the updated base back to Rn.
// Build option: define LDM_WAIT_EN to add the MEM_RDY port and let memory stretch beats;
// without it every beat completes in a single cycle.
module ldm_stm_sequencer
  import ldm_stm_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic              L,
  input  logic              P,
  input  logic              U,
  input  logic              W,
  input  logic [3:0]        RN,
  input  logic [15:0]       REGLIST,
  input  logic [ADDR_W-1:0] BASE,
`ifdef LDM_WAIT_EN
  input  logic              MEM_RDY,
`endif
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] ADDR,
  output logic              MEM_WE,
  output logic [3:0]        REG_A,
  output logic              REG_WE,
  output logic              PC_WE,
  output logic              WB_SEL,
  output logic [DATA_W-1:0] WB_DATA
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

  state_t            state;
  logic [15:0]       mask;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] final_base;
  logic              load;
  logic              wb_en;
  logic [3:0]        rn;

  logic [3:0]        cur_reg;
  logic              mask_any;
  logic [15:0]       mask_clr;
  logic              beat_done;
  logic [4:0]        n_regs;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_base;

  prio_enc16 u_enc (
    .bits  (mask),
    .index (cur_reg),
    .any   (mask_any)
  );

`ifdef LDM_WAIT_EN
  assign beat_done = MEM_RDY;
`else
  assign beat_done = 1'b1;
`endif

  assign mask_clr = mask & ~(16'h0001 << cur_reg);

  // Transfer geometry from the decoded instruction: the lowest register always sits at the
  // lowest address, so descending modes start 4N below the base and still count upward.
  always_comb begin
    n_regs     = popcount16(REGLIST);
    span       = ADDR_W'({n_regs, 2'b00});
    start_addr = U ? (BASE + (P ? STEP : '0))
                   : (BASE - span + (P ? '0 : STEP));
    end_base   = U ? (BASE + span) : (BASE - span);
  end

  // Sequencer state, pending mask and beat address.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state      <= IDLE;
      mask       <= '0;
      addr       <= '0;
      final_base <= '0;
      load       <= 1'b0;
      wb_en      <= 1'b0;
      rn         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            load       <= L;
            // A loaded Rn overrides the updated base, so writeback is dropped in that case.
            wb_en      <= W & ~(L & REGLIST[RN]);
            rn         <= RN;
            mask       <= REGLIST;
            addr       <= start_addr;
            final_base <= end_base;
            state      <= (REGLIST == 16'h0000) ? FIN : XFER;
          end
        end
        XFER: begin
          if (beat_done && mask_any) begin
            mask <= mask_clr;
            addr <= addr + STEP;
            if (mask_clr == 16'h0000) begin
              state <= wb_en ? WB : FIN;
            end
          end
        end
        WB:      state <= FIN;
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode of the port controls; only the load write enables also follow beat completion.
  always_comb begin
    BUSY    = 1'b0;
    DONE    = 1'b0;
    ADDR    = '0;
    MEM_WE  = 1'b0;
    REG_A   = '0;
    REG_WE  = 1'b0;
    PC_WE   = 1'b0;
    WB_SEL  = 1'b0;
    WB_DATA = '0;
    case (state)
      XFER: begin
        BUSY  = 1'b1;
        ADDR  = addr;
        REG_A = cur_reg;
        if (load) begin
          REG_WE = beat_done & (cur_reg != REG_PC);
          PC_WE  = beat_done & (cur_reg == REG_PC);
        end else begin
          MEM_WE = 1'b1;
        end
      end
      WB: begin
        BUSY    = 1'b1;
        REG_A   = rn;
        REG_WE  = 1'b1;
        WB_SEL  = 1'b1;
        WB_DATA = DATA_W'(final_base);
      end
      FIN:     DONE = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer. Flags are grouped as
// {BUSY, DONE, MEM_WE, REG_WE, PC_WE, WB_SEL}.
module tb_ldm_stm_sequencer;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        START, L, P, U, W;
  logic [3:0]  RN;
  logic [15:0] REGLIST;
  logic [31:0] BASE;
  logic        MEM_RDY;
  logic        BUSY, DONE, MEM_WE, REG_WE, PC_WE, WB_SEL;
  logic [31:0] ADDR, WB_DATA;
  logic [3:0]  REG_A;

  int checks   = 0;
  int failures = 0;

  localparam logic [5:0] F_IDLE  = 6'b000000;
  localparam logic [5:0] F_FIN   = 6'b010000;
  localparam logic [5:0] F_STORE = 6'b101000;
  localparam logic [5:0] F_LOAD  = 6'b100100;
  localparam logic [5:0] F_LSTL  = 6'b100000;
  localparam logic [5:0] F_PC    = 6'b100010;
  localparam logic [5:0] F_WB    = 6'b100101;

  ldm_stm_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .START   (START),
    .L       (L),
    .P       (P),
    .U       (U),
    .W       (W),
    .RN      (RN),
    .REGLIST (REGLIST),
    .BASE    (BASE),
`ifdef LDM_WAIT_EN
    .MEM_RDY (MEM_RDY),
`endif
    .BUSY    (BUSY),
    .DONE    (DONE),
    .ADDR    (ADDR),
    .MEM_WE  (MEM_WE),
    .REG_A   (REG_A),
    .REG_WE  (REG_WE),
    .PC_WE   (PC_WE),
    .WB_SEL  (WB_SEL),
    .WB_DATA (WB_DATA)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [5:0] f, input logic [31:0] a,
                            input logic [3:0] r, input logic [31:0] d);
    check({tag, ".flags"}, 32'({BUSY, DONE, MEM_WE, REG_WE, PC_WE, WB_SEL}), 32'(f));
    check({tag, ".addr"},  ADDR, a);
    check({tag, ".reg_a"}, 32'(REG_A), 32'(r));
    check({tag, ".wb"},    WB_DATA, d);
  endtask

  task automatic issue(input logic l, input logic p, input logic u, input logic w,
                       input logic [3:0] rn, input logic [15:0] list, input logic [31:0] base);
    START = 1'b1; L = l; P = p; U = u; W = w; RN = rn; REGLIST = list; BASE = base;
  endtask

  initial begin
    RESET_N = 1'b0; START = 1'b0; L = 1'b0; P = 1'b0; U = 1'b0; W = 1'b0;
    RN = '0; REGLIST = '0; BASE = '0; MEM_RDY = 1'b1;
    tick();
    expect_out("reset", F_IDLE, 32'h0, 4'h0, 32'h0);
    RESET_N = 1'b1;
    tick();
    expect_out("idle", F_IDLE, 32'h0, 4'h0, 32'h0);

    // LDMIA R0!,{R1,R2,R4} base 0x100
    issue(1, 0, 1, 1, 4'd0, 16'h0016, 32'h100);
    tick(); START = 1'b0;
    expect_out("ldmia.b1", F_LOAD, 32'h100, 4'd1, 32'h0);
    tick(); expect_out("ldmia.b2", F_LOAD, 32'h104, 4'd2, 32'h0);
    tick(); expect_out("ldmia.b3", F_LOAD, 32'h108, 4'd4, 32'h0);
    tick(); expect_out("ldmia.wb", F_WB, 32'h0, 4'd0, 32'h10C);
    tick(); expect_out("ldmia.fin", F_FIN, 32'h0, 4'd0, 32'h0);
    tick(); expect_out("ldmia.idle", F_IDLE, 32'h0, 4'd0, 32'h0);

    // STMDB R13!,{R4,R14} base 0x200; a second START mid-transfer must be ignored
    issue(0, 1, 0, 1, 4'd13, 16'h4010, 32'h200);
    tick();
    expect_out("stmdb.b1", F_STORE, 32'h1F8, 4'd4, 32'h0);
    issue(1, 0, 1, 0, 4'd3, 16'hFFFF, 32'h0);
    tick(); START = 1'b0;
    expect_out("stmdb.b2", F_STORE, 32'h1FC, 4'd14, 32'h0);
    tick(); expect_out("stmdb.wb", F_WB, 32'h0, 4'd13, 32'h1F8);
    tick(); expect_out("stmdb.fin", F_FIN, 32'h0, 4'd0, 32'h0);
    tick(); expect_out("stmdb.idle", F_IDLE, 32'h0, 4'd0, 32'h0);

    // LDMIB R2!,{R2,R15} base 0x40: loaded R2 suppresses writeback, R15 goes to the PC
    issue(1, 1, 1, 1, 4'd2, 16'h8004, 32'h40);
    tick(); START = 1'b0;
    expect_out("ldmib.b1", F_LOAD, 32'h44, 4'd2, 32'h0);
    tick(); expect_out("ldmib.pc", F_PC, 32'h48, 4'd15, 32'h0);
    tick(); expect_out("ldmib.fin", F_FIN, 32'h0, 4'd0, 32'h0);

    // Empty list with W=1: straight to FIN, no beats, no writeback
    tick();
    issue(1, 0, 1, 1, 4'd5, 16'h0000, 32'h500);
    tick(); START = 1'b0;
    expect_out("empty.fin", F_FIN, 32'h0, 4'd0, 32'h0);
    tick(); expect_out("empty.idle", F_IDLE, 32'h0, 4'd0, 32'h0);

    // LDMDA R6,{R0,R1,R3} base 0x4: start 0x4-12+4 wraps to 0xFFFFFFFC
    issue(1, 0, 0, 0, 4'd6, 16'h000B, 32'h4);
    tick(); START = 1'b0;
    expect_out("ldmda.b1", F_LOAD, 32'hFFFF_FFFC, 4'd0, 32'h0);
    tick(); expect_out("ldmda.b2", F_LOAD, 32'h0, 4'd1, 32'h0);
    tick(); expect_out("ldmda.b3", F_LOAD, 32'h4, 4'd3, 32'h0);
    tick(); expect_out("ldmda.fin", F_FIN, 32'h0, 4'd0, 32'h0);
    tick();

`ifdef LDM_WAIT_EN
    // LDMIA R0,{R1,R2,R3} base 0x100: second beat stalled for three cycles
    issue(1, 0, 1, 0, 4'd0, 16'h000E, 32'h100);
    tick(); START = 1'b0;
    expect_out("wait.b1", F_LOAD, 32'h100, 4'd1, 32'h0);
    MEM_RDY = 1'b0;
    tick(); expect_out("wait.s1", F_LSTL, 32'h104, 4'd2, 32'h0);
    tick(); expect_out("wait.s2", F_LSTL, 32'h104, 4'd2, 32'h0);
    tick(); expect_out("wait.s3", F_LSTL, 32'h104, 4'd2, 32'h0);
    MEM_RDY = 1'b1; #1;
    expect_out("wait.rdy", F_LOAD, 32'h104, 4'd2, 32'h0);
    tick(); expect_out("wait.b3", F_LOAD, 32'h108, 4'd3, 32'h0);
    tick(); expect_out("wait.fin", F_FIN, 32'h0, 4'd0, 32'h0);
    tick();
`endif

    // Reset during the second of four beats, then a fresh STMIA
    issue(1, 0, 1, 0, 4'd8, 16'h000F, 32'h80);
    tick(); START = 1'b0;
    expect_out("rst.b1", F_LOAD, 32'h80, 4'd0, 32'h0);
    tick(); expect_out("rst.b2", F_LOAD, 32'h84, 4'd1, 32'h0);
    RESET_N = 1'b0; #1;
    expect_out("rst.async", F_IDLE, 32'h0, 4'd0, 32'h0);
    tick(); expect_out("rst.held", F_IDLE, 32'h0, 4'd0, 32'h0);
    RESET_N = 1'b1;
    issue(0, 0, 1, 0, 4'd5, 16'h0080, 32'h300);
    tick(); START = 1'b0;
    expect_out("post.b1", F_STORE, 32'h300, 4'd7, 32'h0);
    tick(); expect_out("post.fin", F_FIN, 32'h0, 4'd0, 32'h0);
    tick(); expect_out("post.idle", F_IDLE, 32'h0, 4'd0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
